// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle CPU control path.
//
// Contents:
//   - opcode values decoded from IR[15:12]
//   - alu_ops codes, shared with alu_control_M
//   - pc_src and alu_src_b mux encodings
//   - FSM state type and state constants used by multicycle_control
package cpu_ctrl_pkg;

  // Opcodes (IR[15:12]); 6..14 are undefined.
  localparam logic [3:0] OpRtype = 4'd0;
  localparam logic [3:0] OpAddi  = 4'd1;
  localparam logic [3:0] OpLw    = 4'd2;
  localparam logic [3:0] OpSw    = 4'd3;
  localparam logic [3:0] OpBeq   = 4'd4;
  localparam logic [3:0] OpJ     = 4'd5;
  localparam logic [3:0] OpHalt  = 4'd15;

  // alu_ops codes; FUNC defers to the func field decode in alu_control_M.
  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluFunc = 3'd2;

  // PC source select.
  localparam logic [1:0] PcSrcAlu    = 2'd0;
  localparam logic [1:0] PcSrcBranch = 2'd1;
  localparam logic [1:0] PcSrcJump   = 2'd2;

  // ALU B operand select.
  localparam logic [1:0] SrcBReg = 2'd0;
  localparam logic [1:0] SrcBOne = 2'd1;
  localparam logic [1:0] SrcBImm = 2'd2;

  // FSM states, kept as plain 4-bit constants so the encoding stays stable.
  typedef logic [3:0] state_t;

  localparam state_t StIdle   = 4'd0;
  localparam state_t StFetch  = 4'd1;
  localparam state_t StDecode = 4'd2;
  localparam state_t StExecR  = 4'd3;
  localparam state_t StWbR    = 4'd4;
  localparam state_t StExecI  = 4'd5;
  localparam state_t StWbI    = 4'd6;
  localparam state_t StAddr   = 4'd7;
  localparam state_t StMemRd  = 4'd8;
  localparam state_t StWbMem  = 4'd9;
  localparam state_t StMemWr  = 4'd10;
  localparam state_t StBranch = 4'd11;
  localparam state_t StJump   = 4'd12;
  localparam state_t StHalt   = 4'd13;

  // True for states that wait on the memory ready handshake.
  function automatic logic is_mem_wait(input state_t st);
    return (st == StFetch) || (st == StMemRd) || (st == StMemWr);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Shared memory-port handshake between the control FSM and the memory.
//
// Signals:
//   mem_ready  memory completes the current read or write this cycle
//   mem_read   read request
//   mem_write  write request
//   iord       address select: 0 = PC, 1 = ALUOut
// Modports:
//   master  the controller (drives requests, samples ready)
//   slave   the memory side
interface multicycle_control_if;
  logic mem_ready;
  logic mem_read;
  logic mem_write;
  logic iord;

  modport master (
    input  mem_ready,
    output mem_read,
    output mem_write,
    output iord
  );

  modport slave (
    output mem_ready,
    input  mem_read,
    input  mem_write,
    input  iord
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait counter with bus-timeout detection.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   clr      clear the count (wins over en)
//   en       a wait cycle: in a memory wait state with mem_ready low
//   timeout  this wait cycle brings the count to MEM_TIMEOUT
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int unsigned W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [W-1:0] Last = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic         at_last;

  assign at_last = (cnt_q == Last);

  // cnt_q holds the wait cycles already spent, so the MEM_TIMEOUT-th wait
  // cycle is the one seen with cnt_q == MEM_TIMEOUT-1.
  assign timeout = en && at_last;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && !at_last) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the multi-cycle CPU datapath.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   start        one-cycle pulse that leaves IDLE
//   opcode       IR[15:12], sampled only in DECODE
//   zero         ALU zero flag, used in BRANCH
//   mem          memory handshake (mem_ready in; mem_read, mem_write, iord out)
//   pc_write, pc_src, ir_write                     PC/IR load control
//   reg_write, reg_dst, mem_to_reg                 register-file writeback
//   alu_src_a, alu_src_b, alu_ops                  ALU operand/op select
//   busy, halted                                   status
//   illegal, bus_err                               sticky error flags
//   retired                                        saturating retire count
module multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             opcode,
  input  logic                   zero,
  multicycle_control_if.master   mem,
  output logic                   pc_write,
  output logic [1:0]             pc_src,
  output logic                   ir_write,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [2:0]             alu_ops,
  output logic                   busy,
  output logic                   halted,
  output logic                   illegal,
  output logic                   bus_err,
  output logic [CNT_W-1:0]       retired
);

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic             illegal_q, bus_err_q;
  logic [CNT_W-1:0] retired_q;

  logic set_illegal, set_bus_err, retire;
  logic tmr_en, tmr_timeout;
  logic iord_c, mem_read_c, mem_write_c;

  // Count only wait cycles; any other cycle clears, so every entry into a
  // wait state starts from zero.
  assign tmr_en = is_mem_wait(state_q) && !mem.mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!tmr_en),
    .en      (tmr_en),
    .timeout (tmr_timeout)
  );

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    retire      = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (mem.mem_ready) begin
          state_d = StDecode;
        end else if (tmr_timeout) begin
          state_d     = StHalt;
          set_bus_err = 1'b1;
        end
      end
      StDecode: begin
        op_d = opcode;
        case (opcode)
          OpRtype: state_d = StExecR;
          OpAddi:  state_d = StExecI;
          OpLw:    state_d = StAddr;
          OpSw:    state_d = StAddr;
          OpBeq:   state_d = StBranch;
          OpJ:     state_d = StJump;
          OpHalt: begin
            state_d = StHalt;
            retire  = 1'b1;
          end
          default: begin
            state_d     = StFetch;
            set_illegal = 1'b1;
          end
        endcase
      end
      StExecR: state_d = StWbR;
      StWbR: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StExecI: state_d = StWbI;
      StWbI: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StAddr: state_d = (op_q == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem.mem_ready) begin
          state_d = StWbMem;
        end else if (tmr_timeout) begin
          state_d     = StHalt;
          set_bus_err = 1'b1;
        end
      end
      StWbMem: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StMemWr: begin
        if (mem.mem_ready) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (tmr_timeout) begin
          state_d     = StHalt;
          set_bus_err = 1'b1;
        end
      end
      StBranch: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StJump: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: a function of state, except the FETCH load strobes
  // (need mem_ready) and the BRANCH PC write (needs zero).
  always_comb begin
    pc_write    = 1'b0;
    pc_src      = PcSrcAlu;
    ir_write    = 1'b0;
    iord_c      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SrcBReg;
    alu_ops     = AluAdd;
    case (state_q)
      StFetch: begin
        mem_read_c = 1'b1;
        alu_src_b  = SrcBOne;
        ir_write   = mem.mem_ready;
        pc_write   = mem.mem_ready;
      end
      StDecode: begin
        alu_src_b = SrcBImm;
      end
      StExecR: begin
        alu_src_a = 1'b1;
        alu_ops   = AluFunc;
      end
      StWbR: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StExecI, StAddr: begin
        alu_src_a = 1'b1;
        alu_src_b = SrcBImm;
      end
      StWbI: begin
        reg_write = 1'b1;
      end
      StMemRd: begin
        iord_c     = 1'b1;
        mem_read_c = 1'b1;
      end
      StWbMem: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        iord_c      = 1'b1;
        mem_write_c = 1'b1;
      end
      StBranch: begin
        alu_src_a = 1'b1;
        alu_ops   = AluSub;
        pc_src    = PcSrcBranch;
        pc_write  = zero;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = PcSrcJump;
      end
      default: ;
    endcase
  end

  assign mem.iord      = iord_c;
  assign mem.mem_read  = mem_read_c;
  assign mem.mem_write = mem_write_c;

  assign busy    = (state_q != StIdle) && (state_q != StHalt);
  assign halted  = (state_q == StHalt);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign retired = retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (retire && (retired_q != {CNT_W{1'b1}})) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

endmodule
